// File: rtl/spi_cmd_receiver.sv
// Mode-0 SPI slave front end for system_controller: oversamples the SPI pins,
// buffers complete 32-bit frames and replays them as clean latch_data strobes.
module spi_cmd_receiver #(
  parameter int FIFO_DEPTH = 4,
  parameter int LATCH_HIGH = 2,
  parameter int LATCH_GAP  = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          sclk,
  input  logic                          cs_n,
  input  logic                          mosi,
  input  logic                          clear_flags,
  output logic [31:0]                   cmd_data,
  output logic                          latch_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_error,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  logic [2:0]    r_sclk_q;
  logic [2:0]    r_cs_q;
  logic [1:0]    r_mosi_q;
  logic [1:0]    r_warm;
  logic          r_armed;
  logic          r_in_frame;
  logic [31:0]   r_shift;
  logic [5:0]    r_bitcnt;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  state_t        r_state;
  logic [15:0]   r_cnt;
  logic          r_latch;
  logic [31:0]   r_cmd;
  logic          r_frame_error;
  logic          r_overflow;

  logic          w_sclk_rise;
  logic          w_cs_rise;
  logic          w_cs_fall;
  logic          w_frame_end;
  logic          w_push_req;
  logic          w_ferr_set;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  state_t        w_state_nxt;
  logic [15:0]   w_cnt_nxt;
  logic          w_latch_nxt;

  assign w_sclk_rise = r_sclk_q[1] & ~r_sclk_q[2];
  assign w_cs_rise   = r_cs_q[1] & ~r_cs_q[2];
  assign w_cs_fall   = ~r_cs_q[1] & r_cs_q[2];

  // Pin synchronizers plus an edge-detect stage for sclk and cs_n.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk_q <= 3'b000;
      r_cs_q   <= 3'b111;
      r_mosi_q <= 2'b00;
      r_warm   <= 2'b00;
    end else begin
      r_sclk_q <= {r_sclk_q[1:0], sclk};
      r_cs_q   <= {r_cs_q[1:0], cs_n};
      r_mosi_q <= {r_mosi_q[0], mosi};
      r_warm   <= {r_warm[0], 1'b1};
    end
  end

  // The cs_n reset value of 1 is not a real pin sample, so arming waits until
  // r_warm shows the synchronized value comes from the pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_armed    <= 1'b0;
      r_in_frame <= 1'b0;
      r_shift    <= 32'h0000_0000;
      r_bitcnt   <= 6'd0;
    end else if (!r_armed) begin
      if (r_warm[1] && r_cs_q[1]) begin
        r_armed <= 1'b1;
      end
    end else if (w_cs_fall) begin
      r_in_frame <= 1'b1;
      r_shift    <= 32'h0000_0000;
      r_bitcnt   <= 6'd0;
    end else if (r_in_frame && w_cs_rise) begin
      r_in_frame <= 1'b0;
    end else if (r_in_frame && w_sclk_rise) begin
      r_shift <= {r_shift[30:0], r_mosi_q[1]};
      if (r_bitcnt != 6'd33) begin
        r_bitcnt <= r_bitcnt + 6'd1;
      end
    end
  end

  assign w_frame_end = r_in_frame & w_cs_rise;
  assign w_push_req  = w_frame_end & (r_bitcnt == 6'd32);
  assign w_ferr_set  = w_frame_end & (r_bitcnt != 6'd32) & (r_bitcnt != 6'd0);

  assign w_full    = (r_count == LW'(FIFO_DEPTH));
  assign w_empty   = (r_count == LW'(0));
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovf_set = w_push_req & w_full & ~w_pop;

  // FIFO storage; contents are don't-care until counted in r_count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Strobe FSM; GAP expiring with work queued issues directly so
  // back-to-back commands repeat every LATCH_HIGH+LATCH_GAP cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch_nxt = r_latch;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_latch_nxt = 1'b1;
          w_cnt_nxt   = 16'(LATCH_HIGH - 1);
          w_state_nxt = ST_HIGH;
        end else begin
          w_latch_nxt = 1'b0;
        end
      end
      ST_HIGH: begin
        if (r_cnt == 16'd0) begin
          w_latch_nxt = 1'b0;
          w_cnt_nxt   = 16'(LATCH_GAP - 1);
          w_state_nxt = ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt != 16'd0) begin
          w_cnt_nxt = r_cnt - 16'd1;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_latch_nxt = 1'b1;
          w_cnt_nxt   = 16'(LATCH_HIGH - 1);
          w_state_nxt = ST_HIGH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_latch_nxt = 1'b0;
        w_cnt_nxt   = 16'd0;
      end
    endcase
  end

  // FSM state, strobe and command registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_latch <= 1'b0;
      r_cmd   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_latch <= w_latch_nxt;
      if (w_pop) begin
        r_cmd <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky flags: a set in the same cycle as clear_flags wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_frame_error <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_frame_error <= w_ferr_set | (r_frame_error & ~clear_flags);
      r_overflow    <= w_ovf_set | (r_overflow & ~clear_flags);
    end
  end

  assign cmd_data    = r_cmd;
  assign latch_data  = r_latch;
  assign fifo_level  = r_count;
  assign frame_error = r_frame_error;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Scoreboard bench for spi_cmd_receiver: a default instance plus a slow-strobe
// instance used to fill the FIFO, overflow it and reset it mid-pulse.
module tb_spi_cmd_receiver;

  logic        clock;
  logic        reset1, sclk1, cs1, mosi1, clr1;
  logic [31:0] cmd1;
  logic        latch1, ferr1, ovf1;
  logic [2:0]  lvl1;
  logic        reset2, sclk2, cs2, mosi2, clr2;
  logic [31:0] cmd2;
  logic        latch2, ferr2, ovf2;
  logic [2:0]  lvl2;

  int n_checks = 0;
  int n_err    = 0;
  int strobes1 = 0;
  int strobes2 = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  spi_cmd_receiver u_dut (
    .clock(clock), .reset(reset1), .sclk(sclk1), .cs_n(cs1), .mosi(mosi1),
    .clear_flags(clr1), .cmd_data(cmd1), .latch_data(latch1),
    .fifo_level(lvl1), .frame_error(ferr1), .overflow(ovf1)
  );

  spi_cmd_receiver #(.FIFO_DEPTH(4), .LATCH_HIGH(3000), .LATCH_GAP(2)) u_slow (
    .clock(clock), .reset(reset2), .sclk(sclk2), .cs_n(cs2), .mosi(mosi2),
    .clear_flags(clr2), .cmd_data(cmd2), .latch_data(latch2),
    .fifo_level(lvl2), .frame_error(ferr2), .overflow(ovf2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pin_cs(input int sel, input logic v);
    if (sel == 0) cs1 = v; else cs2 = v;
  endtask

  task automatic pin_sclk(input int sel, input logic v);
    if (sel == 0) sclk1 = v; else sclk2 = v;
  endtask

  task automatic pin_mosi(input int sel, input logic v);
    if (sel == 0) mosi1 = v; else mosi2 = v;
  endtask

  // Lower cs_n and clock out n bits MSB first; bits past 32 are ones. cs_n stays low.
  task automatic spi_bits(input int sel, input logic [31:0] w, input int n, input int half);
    logic [31:0] sh;
    sh = w;
    pin_cs(sel, 1'b0);
    wait_cyc(half);
    for (int i = 0; i < n; i++) begin
      pin_mosi(sel, (i < 32) ? sh[31] : 1'b1);
      sh = sh << 1;
      wait_cyc(half);
      pin_sclk(sel, 1'b1);
      wait_cyc(half);
      pin_sclk(sel, 1'b0);
    end
    wait_cyc(half);
  endtask

  // Whole frame followed by two sclk periods of deselect.
  task automatic spi_frame(input int sel, input logic [31:0] w, input int n, input int half);
    spi_bits(sel, w, n, half);
    pin_cs(sel, 1'b1);
    wait_cyc(4 * half);
  endtask

  // Monitor: pops the scoreboard at every latch_data rise, checks width, gap, period.
  task automatic monitor(input int sel, input int lh, input int lg, input int per);
    logic        prev = 1'b0;
    logic        l, r;
    logic [31:0] d, e;
    int          hi = 0, lo = 0, cyc = 0, last_rise = -1;
    bit          seen = 1'b0, abort = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      l = (sel == 0) ? latch1 : latch2;
      r = (sel == 0) ? reset1 : reset2;
      d = (sel == 0) ? cmd1 : cmd2;
      if (l === 1'b1 && prev === 1'b0) begin
        if (((sel == 0) ? q1.size() : q2.size()) == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL strobe%0d: unexpected word 0x%08h, expected no strobe", sel, d);
        end else begin
          e = (sel == 0) ? q1.pop_front() : q2.pop_front();
          chk($sformatf("cmd%0d", sel), d, e);
        end
        if (seen) chk($sformatf("gap%0d_min", sel), 32'(lo >= lg), 32'd1);
        if (per > 0 && last_rise >= 0) chk($sformatf("period%0d", sel), 32'(cyc - last_rise), 32'(per));
        if (sel == 0) strobes1++; else strobes2++;
        hi = 1;
        abort = r;
        last_rise = cyc;
      end else if (l === 1'b1) begin
        hi++;
        if (r) abort = 1'b1;
      end else if (prev === 1'b1) begin
        if (!abort) chk($sformatf("width%0d", sel), 32'(hi), 32'(lh));
        lo = 1;
        seen = 1'b1;
      end else begin
        lo++;
      end
      if (r) begin
        seen = 1'b0;
        last_rise = -1;
      end
      prev = l;
    end
  endtask

  initial monitor(0, 2, 2, 0);
  initial monitor(1, 3000, 2, 3002);

  initial begin
    int k;
    int t;
    reset1 = 1'b1; sclk1 = 1'b0; cs1 = 1'b1; mosi1 = 1'b0; clr1 = 1'b0;
    reset2 = 1'b1; sclk2 = 1'b0; cs2 = 1'b1; mosi2 = 1'b0; clr2 = 1'b0;
    wait_cyc(3);
    reset1 = 1'b0;
    reset2 = 1'b0;
    @(negedge clock);
    chk("rst_cmd", cmd1, 32'h0);
    chk("rst_latch", 32'(latch1), 32'h0);
    chk("rst_level", 32'(lvl1), 32'h0);
    chk("rst_ferr", 32'(ferr1), 32'h0);
    chk("rst_ovf", 32'(ovf1), 32'h0);
    chk("rst_latch_slow", 32'(latch2), 32'h0);
    wait_cyc(5);

    // Single frame with latency measured from the cs_n rise.
    q1.push_back(32'hC800_0000);
    spi_bits(0, 32'hC800_0000, 32, 8);
    pin_cs(0, 1'b1);
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (latch1 === 1'b1) break;
    end
    chk("latency", 32'(k), 32'd4);
    wait_cyc(20);
    chk("single_level", 32'(lvl1), 32'd0);
    chk("single_ferr", 32'(ferr1), 32'd0);

    // Burst of six frames.
    for (int i = 1; i <= 6; i++) begin
      q1.push_back({16'(i), 16'(i)});
      spi_frame(0, {16'(i), 16'(i)}, 32, 8);
    end
    wait_cyc(10);
    chk("burst_ovf", 32'(ovf1), 32'd0);
    chk("burst_level", 32'(lvl1), 32'd0);

    // Short frame, then long frame with clear_flags coinciding with the set.
    spi_frame(0, 32'hFFFF_FFFF, 31, 8);
    chk("short_ferr", 32'(ferr1), 32'd1);
    chk("short_level", 32'(lvl1), 32'd0);
    clr1 = 1'b1;
    wait_cyc(1);
    clr1 = 1'b0;
    wait_cyc(1);
    chk("clear_ferr", 32'(ferr1), 32'd0);
    spi_bits(0, 32'h1234_5678, 33, 8);
    pin_cs(0, 1'b1);
    wait_cyc(2);
    clr1 = 1'b1;
    wait_cyc(1);
    clr1 = 1'b0;
    wait_cyc(20);
    chk("long_ferr_set_wins", 32'(ferr1), 32'd1);
    chk("long_level", 32'(lvl1), 32'd0);
    clr1 = 1'b1;
    wait_cyc(1);
    clr1 = 1'b0;
    wait_cyc(1);
    chk("clear_ferr2", 32'(ferr1), 32'd0);

    // Empty select, then idle sclk with cs_n high.
    pin_cs(0, 1'b0);
    wait_cyc(16);
    pin_cs(0, 1'b1);
    wait_cyc(16);
    chk("empty_ferr", 32'(ferr1), 32'd0);
    chk("empty_level", 32'(lvl1), 32'd0);
    for (int i = 0; i < 32; i++) begin
      pin_mosi(0, 1'b1);
      pin_sclk(0, 1'b1);
      wait_cyc(4);
      pin_sclk(0, 1'b0);
      wait_cyc(4);
    end
    wait_cyc(8);
    chk("idle_ferr", 32'(ferr1), 32'd0);
    chk("idle_level", 32'(lvl1), 32'd0);

    // Reset in the middle of a frame.
    spi_bits(0, 32'hDEAD_0000, 16, 8);
    reset1 = 1'b1;
    wait_cyc(2);
    reset1 = 1'b0;
    @(negedge clock);
    chk("midframe_rst_cmd", cmd1, 32'h0);
    spi_bits(0, 32'hBEEF_0000, 16, 8);
    pin_cs(0, 1'b1);
    wait_cyc(40);
    chk("midframe_ferr", 32'(ferr1), 32'd0);
    chk("midframe_level", 32'(lvl1), 32'd0);
    q1.push_back(32'hA5A5_A5A5);
    spi_frame(0, 32'hA5A5_A5A5, 32, 8);
    wait_cyc(10);
    chk("strobes_main", 32'(strobes1), 32'd8);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    // Slow instance: frame 1 issues at once, 2..5 fill the FIFO, 6 is dropped.
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) q2.push_back(32'h5A00_0000 | 32'(i));
      spi_frame(1, 32'h5A00_0000 | 32'(i), 32, 4);
    end
    wait_cyc(5);
    chk("ovf_set", 32'(ovf2), 32'd1);
    chk("ovf_level_full", 32'(lvl2), 32'd4);
    chk("ovf_ferr", 32'(ferr2), 32'd0);
    clr2 = 1'b1;
    wait_cyc(1);
    clr2 = 1'b0;
    wait_cyc(1);
    chk("ovf_clear", 32'(ovf2), 32'd0);
    t = 0;
    while (strobes2 < 3 && t < 10000) begin
      wait_cyc(1);
      t++;
    end
    chk("strobe3_reached", 32'(strobes2 >= 3), 32'd1);
    wait_cyc(3);
    chk("queued_two", 32'(lvl2), 32'd2);
    chk("pulse_high", 32'(latch2), 32'd1);

    // Reset during HIGH with two entries queued.
    reset2 = 1'b1;
    wait_cyc(1);
    reset2 = 1'b0;
    @(negedge clock);
    chk("midpulse_latch", 32'(latch2), 32'd0);
    chk("midpulse_level", 32'(lvl2), 32'd0);
    q2.delete();
    wait_cyc(7000);
    chk("no_more_strobes", 32'(strobes2), 32'd3);
    chk("slow_level_end", 32'(lvl2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
